hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard and forwarding unit for the 5-stage RISC-V pipeline. Tracks destination registers of in-flight instructions between ID and WB in a shift-register scoreboard. From this it generates the ID stall/bubble request and registered forwarding selects aligned with the EX stage. Adds load-use detection, branch-flush bubbles and a global pipeline hold, none of which the current pipeline has.

## Interface
Parameters:
- STAGES, 2, scoreboard entries between ID and WB (entry 0 = EX, STAGES-1 = last before WB); range 1..6
- REG_AW, 5, register address width
- LOAD_STAGE, 2, first pipeline register index holding load data (1 = EX/MEM, 2 = MEM/WB, …); range 1..STAGES
- FW, $clog2(STAGES+1), forwarding select width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- hold_i  in  1  global freeze (memory wait); scoreboard and fwd registers hold
- flush_i  in  1  taken branch resolved in EX; kills the ID instruction
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i, id_rs2_i  in  REG_AW  ID source registers
- id_rs1_use_i, id_rs2_use_i  in  1  source actually read
- id_rd_i  in  REG_AW  ID destination
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- stall_o  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational)
- fwd_a_o, fwd_b_o  out  FW  EX operand select: 0 = register file, s = output of pipeline register s (registered)

## Operation
- Entry = {valid, rd, regwrite, memread}. Match(i, rs) = entry[i].valid & regwrite & rd==rs & rs!=0 & use bit set.
- Per source, producer = lowest-index matching entry (youngest wins).
- Hazard with forwarding: producer i is a load and i+1 < LOAD_STAGE. Defaults: load in EX, consumer in ID → 1 stall.
- Otherwise the next fwd select for that operand = i+1; no producer → 0.
- stall_o = hold_i | (id_valid_i & !flush_i & hazard on rs1 or rs2).
- Shift when !hold_i: entry[k] <= entry[k-1]; entry[0] <= real ID instruction if id_valid_i & !stall_o & !flush_i, else bubble (valid=0).
- fwd regs load the computed selects when the ID instruction enters entry 0, otherwise 0 (bubbles never forward).
- The WB stage is not tracked. The register file must be write-first; a same-cycle WB write is visible to the ID read.

## Timing
- Reset (rst_i low, async): all entries invalid, fwd_a_o = fwd_b_o = 0, stall_o = hold_i.
- stall_o: zero-latency, combinational from ID inputs and scoreboard.
- fwd_*_o: valid one cycle after the instruction leaves ID, i.e. while it is in EX.
- Load-use with defaults: exactly one bubble, then fwd = 2 (MEM/WB).
- flush_i and hazard in the same cycle: flush wins, stall_o = 0, a bubble is pushed.
- hold_i and flush_i together: hold wins; the flush must be re-presented after hold drops.
- rst_i asserted mid-stall: clears everything; the first post-reset instruction never stalls.

## Configuration
- HAZARD_FORWARD_EN defined: forwarding behaviour as above.
- Undefined: fwd_*_o tied to 0. Hazard = any match in entries 0..STAGES-1 regardless of memread. The ID instruction stalls until its producer reaches WB; with defaults, a back-to-back dependency gives 2 stalls.

## Structure
- Package cpu_pipe_pkg: sb_entry_t struct, FWD_REGFILE = 0, STAGES/LOAD_STAGE default constants, shared with the future parametrised CPU top.
- Sub-module hazard_match: one per source operand. Contains the priority search over entries and returns {hit, index, is_load}.

## Test plan
- Reset, all entries invalid, then `add x5,x1,x2` followed by `sub x6,x5,x3` → no stall; fwd_a_o = 1 while sub is in EX.
- `lw x5,0(x1)` followed by `add x6,x5,x5` → stall_o = 1 for exactly 1 cycle; then fwd_a_o = fwd_b_o = 2.
- Dependency through rd = x0 (`addi x0,x1,1`, `add x2,x0,x0`) → no stall, fwd = 0.
- Dependent instruction in ID during a load-use hazard while flush_i = 1 → stall_o = 0, entry 0 becomes a bubble, fwd = 0 next cycle.
- hold_i = 1 for 3 cycles mid-sequence → entries and fwd frozen, stall_o = 1; the sequence resumes unchanged.
- HAZARD_FORWARD_EN undefined: `add x5`, then `sub` using x5 → 2 stall cycles, fwd always 0; async reset during the second stall clears stall_o.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline types and defaults for the hazard/forwarding unit.
// The rd field is sized for the widest supported register address; narrower ids are zero-extended.
package cpu_pipe_pkg;
    localparam int STAGES_DEF     = 2;
    localparam int LOAD_STAGE_DEF = 2;
    localparam int REG_AW_MAX     = 8;
    localparam int FWD_REGFILE    = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } sb_entry_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: priority search of the scoreboard for one source operand.
// Returns the lowest-index (youngest) matching producer and whether it is a load.
module hazard_match
    import cpu_pipe_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int REG_AW = 5,
    parameter int FW     = $clog2(STAGES + 1)
) (
    input  sb_entry_t [STAGES-1:0] entries,
    input  logic [REG_AW-1:0]      rs,
    input  logic                   rs_use,
    output logic                   hit,
    output logic [FW-1:0]          idx,
    output logic                   is_load
);
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites.
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].regwrite && rs_use && rs != '0 &&
                entries[k].rd == REG_AW_MAX'(rs)) begin
                hit     = 1'b1;
                idx     = FW'(k);
                is_load = entries[k].memread;
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall generation and EX-aligned forwarding selects.
// Define HAZARD_FORWARD_EN for forwarding; otherwise consumers stall until the producer reaches WB.
module hazard_scoreboard
    import cpu_pipe_pkg::*;
#(
    parameter int STAGES     = STAGES_DEF,
    parameter int REG_AW     = 5,
    parameter int LOAD_STAGE = LOAD_STAGE_DEF,
    parameter int FW         = $clog2(STAGES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_use_i,
    input  logic              id_rs2_use_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    output logic              stall_o,
    output logic [FW-1:0]     fwd_a_o,
    output logic [FW-1:0]     fwd_b_o
);
    sb_entry_t [STAGES-1:0] sb;
    logic                   hit_a, hit_b, load_a, load_b, hz_a, hz_b, push;
    logic [FW-1:0]          idx_a, idx_b;

    hazard_match #(.STAGES(STAGES), .REG_AW(REG_AW), .FW(FW)) u_match_a (
        .entries(sb), .rs(id_rs1_i), .rs_use(id_rs1_use_i),
        .hit(hit_a), .idx(idx_a), .is_load(load_a)
    );

    hazard_match #(.STAGES(STAGES), .REG_AW(REG_AW), .FW(FW)) u_match_b (
        .entries(sb), .rs(id_rs2_i), .rs_use(id_rs2_use_i),
        .hit(hit_b), .idx(idx_b), .is_load(load_b)
    );

    assign stall_o = hold_i | (id_valid_i & ~flush_i & (hz_a | hz_b));
    assign push    = id_valid_i & ~stall_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sb <= '0;
        end else if (!hold_i) begin
            for (int k = STAGES - 1; k > 0; k--) sb[k] <= sb[k-1];
            sb[0] <= push ? {1'b1, REG_AW_MAX'(id_rd_i), id_regwrite_i, id_memread_i} : '0;
        end
    end

`ifdef HAZARD_FORWARD_EN
    // Load data first exists in pipeline register LOAD_STAGE; anything younger must wait.
    assign hz_a = hit_a & load_a & (int'(idx_a) + 1 < LOAD_STAGE);
    assign hz_b = hit_b & load_b & (int'(idx_b) + 1 < LOAD_STAGE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_a_o <= FW'(FWD_REGFILE);
            fwd_b_o <= FW'(FWD_REGFILE);
        end else if (!hold_i) begin
            fwd_a_o <= (push & hit_a) ? idx_a + FW'(1) : FW'(FWD_REGFILE);
            fwd_b_o <= (push & hit_b) ? idx_b + FW'(1) : FW'(FWD_REGFILE);
        end
    end
`else
    logic unused_fwd;
    assign hz_a       = hit_a;
    assign hz_b       = hit_b;
    assign fwd_a_o    = FW'(FWD_REGFILE);
    assign fwd_b_o    = FW'(FWD_REGFILE);
    assign unused_fwd = ^{idx_a, idx_b, load_a, load_b, LOAD_STAGE[0]};
`endif
endmodule
